// File: rtl/id_ex_stage.sv
// id_ex_stage: RV64I integer decode / operand stage feeding the 64-bit ALU.
//
// Decodes the supported R-type and I-type ALU instructions, reads a NREG x BW
// register file (x0 is hardwired to zero) and registers operand A, operand B,
// ALUOP and destination info into the ID/EX pipeline register.
// Write-back from the ALU result bypasses into the same-cycle operand read.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   id_valid, id_instr  incoming instruction and its qualifier
//   stall, flush        hazard control (flush wins over stall)
//   wb_en, wb_rd,
//   wb_data             register-file write port
//   ex_valid, ex_a,
//   ex_b, ex_aluop,
//   ex_rd, ex_we        ID/EX register contents driving the ALU
//   illegal             one-cycle pulse when an unsupported word is consumed
module id_ex_stage #(
    parameter int BW   = 64,
    parameter int NREG = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [31:0]   id_instr,
    input  logic          stall,
    input  logic          flush,
    input  logic          wb_en,
    input  logic [4:0]    wb_rd,
    input  logic [BW-1:0] wb_data,
    output logic          ex_valid,
    output logic [BW-1:0] ex_a,
    output logic [BW-1:0] ex_b,
    output logic [2:0]    ex_aluop,
    output logic [4:0]    ex_rd,
    output logic          ex_we,
    output logic          illegal
);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;

    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    logic [BW-1:0] rf [NREG];

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1, rs2, rd;

    assign opcode = id_instr[6:0];
    assign rd     = id_instr[11:7];
    assign funct3 = id_instr[14:12];
    assign rs1    = id_instr[19:15];
    assign rs2    = id_instr[24:20];
    assign funct7 = id_instr[31:25];

    logic          wb_act;
    logic [BW-1:0] rs1_val, rs2_val;

    // A write this cycle is visible to this cycle's read (write-to-read bypass).
    assign wb_act  = wb_en && (wb_rd != 5'd0);
    assign rs1_val = (rs1 == 5'd0) ? '0 : (wb_act && wb_rd == rs1) ? wb_data : rf[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : (wb_act && wb_rd == rs2) ? wb_data : rf[rs2];

    logic          dec_legal;
    logic [2:0]    dec_op;
    logic [BW-1:0] dec_b;

    always_comb begin
        dec_legal = 1'b0;
        dec_op    = ALU_ADD;
        dec_b     = '0;
        case (opcode)
            OP_REG: begin
                dec_b = rs2_val;
                case (funct3)
                    3'b000: begin
                        if (funct7 == 7'b0000000) begin
                            dec_legal = 1'b1;
                            dec_op    = ALU_ADD;
                        end else if (funct7 == 7'b0100000) begin
                            dec_legal = 1'b1;
                            dec_op    = ALU_SUB;
                        end
                    end
                    3'b111: begin dec_legal = (funct7 == 7'b0); dec_op = ALU_AND; end
                    3'b110: begin dec_legal = (funct7 == 7'b0); dec_op = ALU_OR;  end
                    3'b100: begin dec_legal = (funct7 == 7'b0); dec_op = ALU_XOR; end
                    3'b001: begin dec_legal = (funct7 == 7'b0); dec_op = ALU_SLL; end
                    3'b101: begin dec_legal = (funct7 == 7'b0); dec_op = ALU_SRL; end
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_IMM: begin
                dec_b = {{(BW-12){id_instr[31]}}, id_instr[31:20]};
                case (funct3)
                    3'b000: begin dec_legal = 1'b1; dec_op = ALU_ADD; end
                    3'b111: begin dec_legal = 1'b1; dec_op = ALU_AND; end
                    3'b110: begin dec_legal = 1'b1; dec_op = ALU_OR;  end
                    3'b100: begin dec_legal = 1'b1; dec_op = ALU_XOR; end
                    // RV64 shifts use a 6-bit shamt; upper bits must be zero
                    // (this also rejects SRAI).
                    3'b001: begin
                        dec_legal = (id_instr[31:26] == 6'b0);
                        dec_op    = ALU_SLL;
                        dec_b     = {{(BW-6){1'b0}}, id_instr[25:20]};
                    end
                    3'b101: begin
                        dec_legal = (id_instr[31:26] == 6'b0);
                        dec_op    = ALU_SRL;
                        dec_b     = {{(BW-6){1'b0}}, id_instr[25:20]};
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    logic          vld_p1;
    logic [BW-1:0] a_p1, b_p1;
    logic [2:0]    op_p1;
    logic [4:0]    rd_p1;
    logic          we_p1;
    logic          ill_p1;

    // ---- ID -> EX pipeline boundary (register file shares the same edge) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            a_p1   <= '0;
            b_p1   <= '0;
            op_p1  <= ALU_ADD;
            rd_p1  <= 5'd0;
            we_p1  <= 1'b0;
            ill_p1 <= 1'b0;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            if (wb_act) rf[wb_rd] <= wb_data;
            ill_p1 <= 1'b0;
            if (flush || (!stall && (!id_valid || !dec_legal))) begin
                vld_p1 <= 1'b0;
                a_p1   <= '0;
                b_p1   <= '0;
                op_p1  <= ALU_ADD;
                rd_p1  <= 5'd0;
                we_p1  <= 1'b0;
                ill_p1 <= !flush && id_valid && !dec_legal;
            end else if (!stall) begin
                vld_p1 <= 1'b1;
                a_p1   <= rs1_val;
                b_p1   <= dec_b;
                op_p1  <= dec_op;
                rd_p1  <= rd;
                we_p1  <= (rd != 5'd0);
            end
        end
    end

    assign ex_valid = vld_p1;
    assign ex_a     = a_p1;
    assign ex_b     = b_p1;
    assign ex_aluop = op_p1;
    assign ex_rd    = rd_p1;
    assign ex_we    = we_p1;
    assign illegal  = ill_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage.
module tb_id_ex_stage;

    localparam int BW = 64;

    logic          clk = 1'b0;
    logic          rst, id_valid, stall, flush, wb_en;
    logic [31:0]   id_instr;
    logic [4:0]    wb_rd;
    logic [BW-1:0] wb_data;
    logic          ex_valid, ex_we, illegal;
    logic [BW-1:0] ex_a, ex_b;
    logic [2:0]    ex_aluop;
    logic [4:0]    ex_rd;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.BW(BW), .NREG(32)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
        .stall(stall), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
        .ex_aluop(ex_aluop), .ex_rd(ex_rd), .ex_we(ex_we), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_instr = 32'h0; stall = 1'b0; flush = 1'b0;
        wb_en = 1'b0; wb_rd = 5'd0; wb_data = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if ({ex_valid, ex_we, illegal, ex_aluop, ex_rd} !== 11'b0 || ex_a !== '0 || ex_b !== '0) begin
            errors++;
            $display("FAIL reset_state got v=%b we=%b ill=%b op=%b rd=%0d a=%h b=%h required all zero",
                     ex_valid, ex_we, illegal, ex_aluop, ex_rd, ex_a, ex_b);
        end
    endtask

    task automatic test_addi();
        idle();
        id_valid = 1'b1; id_instr = 32'h00500093;   // ADDI x1,x0,5
        step();
        checks++;
        if ({ex_valid, ex_we, ex_aluop, ex_rd} !== {1'b1, 1'b1, 3'b000, 5'd1} || ex_a !== 64'd0 || ex_b !== 64'd5) begin
            errors++;
            $display("FAIL addi got v=%b we=%b op=%b rd=%0d a=%h b=%h required 1 1 000 1 0 5",
                     ex_valid, ex_we, ex_aluop, ex_rd, ex_a, ex_b);
        end
        id_instr = 32'hFFF00113;                     // ADDI x2,x0,-1
        step();
        checks++;
        if (ex_b !== 64'hFFFF_FFFF_FFFF_FFFF || ex_aluop !== 3'b000 || ex_rd !== 5'd2) begin
            errors++;
            $display("FAIL addi_neg got b=%h op=%b rd=%0d required ffffffffffffffff 000 2", ex_b, ex_aluop, ex_rd);
        end
    endtask

    task automatic test_bypass();
        idle();
        id_valid = 1'b1; id_instr = 32'h40318233;    // SUB x4,x3,x3
        wb_en = 1'b1; wb_rd = 5'd3; wb_data = 64'h1234;
        step();
        checks++;
        if (ex_a !== 64'h1234 || ex_b !== 64'h1234 || ex_aluop !== 3'b001 || ex_rd !== 5'd4) begin
            errors++;
            $display("FAIL bypass got a=%h b=%h op=%b rd=%0d required 1234 1234 001 4", ex_a, ex_b, ex_aluop, ex_rd);
        end
        wb_en = 1'b0;
        id_instr = 32'h000183B3;                     // ADD x7,x3,x0
        step();
        checks++;
        if (ex_a !== 64'h1234 || ex_b !== 64'd0) begin
            errors++;
            $display("FAIL array_read got a=%h b=%h required 1234 0", ex_a, ex_b);
        end
    endtask

    task automatic test_shifts();
        idle();
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 64'd1;
        step();
        wb_rd = 5'd2; wb_data = 64'hF0;
        step();
        idle();
        id_valid = 1'b1; id_instr = 32'h03F09293;    // SLLI x5,x1,63
        step();
        checks++;
        if (ex_a !== 64'd1 || ex_b !== 64'd63 || ex_aluop !== 3'b101 || ex_rd !== 5'd5 || ex_we !== 1'b1) begin
            errors++;
            $display("FAIL slli got a=%h b=%h op=%b rd=%0d required 1 3f 101 5", ex_a, ex_b, ex_aluop, ex_rd);
        end
        id_instr = 32'h0020D333;                     // SRL x6,x1,x2
        step();
        checks++;
        if (ex_a !== 64'd1 || ex_b !== 64'hF0 || ex_aluop !== 3'b110 || ex_rd !== 5'd6) begin
            errors++;
            $display("FAIL srl got a=%h b=%h op=%b rd=%0d required 1 f0 110 6", ex_a, ex_b, ex_aluop, ex_rd);
        end
    endtask

    task automatic test_x0();
        idle();
        id_valid = 1'b1; id_instr = 32'h000000B3;    // ADD x1,x0,x0
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 64'd7;
        step();
        checks++;
        if (ex_a !== 64'd0 || ex_b !== 64'd0 || ex_we !== 1'b1) begin
            errors++;
            $display("FAIL x0_bypass got a=%h b=%h we=%b required 0 0 1", ex_a, ex_b, ex_we);
        end
        wb_en = 1'b0;
        step();
        checks++;
        if (ex_a !== 64'd0 || ex_b !== 64'd0) begin
            errors++;
            $display("FAIL x0_array got a=%h b=%h required 0 0", ex_a, ex_b);
        end
        id_instr = 32'h00108033;                     // ADD x0,x1,x1
        step();
        checks++;
        if ({ex_valid, ex_we, ex_rd} !== {1'b1, 1'b0, 5'd0} || ex_a !== 64'd1 || ex_b !== 64'd1) begin
            errors++;
            $display("FAIL rd_zero got v=%b we=%b rd=%0d a=%h b=%h required 1 0 0 1 1",
                     ex_valid, ex_we, ex_rd, ex_a, ex_b);
        end
    endtask

    task automatic test_stall();
        idle();
        id_valid = 1'b1; id_instr = 32'h00500093;    // ADDI x1,x0,5
        step();
        stall = 1'b1; id_instr = 32'h0020D333;
        wb_en = 1'b1; wb_rd = 5'd9; wb_data = 64'h55;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({ex_valid, ex_we, ex_aluop, ex_rd} !== {1'b1, 1'b1, 3'b000, 5'd1} || ex_b !== 64'd5 || illegal !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d] got v=%b op=%b rd=%0d b=%h required 1 000 1 5",
                         i, ex_valid, ex_aluop, ex_rd, ex_b);
            end
        end
        stall = 1'b0; wb_en = 1'b0;
        id_instr = 32'h00048433;                     // ADD x8,x9,x0
        step();
        checks++;
        if (ex_a !== 64'h55 || ex_rd !== 5'd8) begin
            errors++;
            $display("FAIL stall_wb got a=%h rd=%0d required 55 8", ex_a, ex_rd);
        end
    endtask

    task automatic test_stall_flush();
        idle();
        id_valid = 1'b1; id_instr = 32'h00500093;
        stall = 1'b1; flush = 1'b1;
        step();
        checks++;
        if ({ex_valid, ex_we, ex_aluop, ex_rd} !== 10'b0 || ex_a !== '0 || ex_b !== '0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL stall_flush got v=%b we=%b op=%b rd=%0d b=%h ill=%b required bubble",
                     ex_valid, ex_we, ex_aluop, ex_rd, ex_b, illegal);
        end
    endtask

    task automatic test_illegal();
        idle();
        id_valid = 1'b1; id_instr = 32'h00000000;
        step();
        checks++;
        if (illegal !== 1'b1 || ex_valid !== 1'b0 || ex_we !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pulse got ill=%b v=%b we=%b required 1 0 0", illegal, ex_valid, ex_we);
        end
        id_valid = 1'b0;
        step();
        checks++;
        if (illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal_clear got ill=%b required 0", illegal);
        end
        id_valid = 1'b1; id_instr = 32'h4010D293;    // SRAI: not supported
        step();
        checks++;
        if (illegal !== 1'b1 || ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL illegal_srai got ill=%b v=%b required 1 0", illegal, ex_valid);
        end
        id_instr = 32'h00500093;
        step();
        stall = 1'b1; id_instr = 32'h00000000;
        step();
        checks++;
        if (illegal !== 1'b0 || ex_valid !== 1'b1 || ex_b !== 64'd5) begin
            errors++;
            $display("FAIL illegal_stall got ill=%b v=%b b=%h required 0 1 5", illegal, ex_valid, ex_b);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        id_valid = 1'b1; id_instr = 32'h00500093;
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 64'h77;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({ex_valid, ex_we, illegal, ex_aluop, ex_rd} !== 11'b0 || ex_a !== '0 || ex_b !== '0) begin
            errors++;
            $display("FAIL reset_mid got v=%b we=%b ill=%b op=%b rd=%0d a=%h b=%h required bubble",
                     ex_valid, ex_we, illegal, ex_aluop, ex_rd, ex_a, ex_b);
        end
        wb_en = 1'b0;
        id_instr = 32'h00108533;                     // ADD x10,x1,x1
        step();
        checks++;
        if (ex_a !== 64'd0 || ex_b !== 64'd0) begin
            errors++;
            $display("FAIL reset_x1 got a=%h b=%h required 0 0", ex_a, ex_b);
        end
        id_instr = 32'h00018533;                     // ADD x10,x3,x0
        step();
        checks++;
        if (ex_a !== 64'd0) begin
            errors++;
            $display("FAIL reset_x3 got a=%h required 0", ex_a);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_addi();
        test_bypass();
        test_shifts();
        test_x0();
        test_stall();
        test_stall_flush();
        test_illegal();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode/operand stage that directly feeds the 64-bit ALU: decodes an RV64I integer instruction and reads a 32x64 register file.
- Registers operand A, operand B, the 3-bit ALUOP and destination info into the ID/EX pipeline register that drives the ALU inputs.
- Accepts the ALU result back through a write-back port, with same-cycle write-to-read bypass.
- Supports stall and flush from the hazard logic.

Parameters:
- BW, 64, data/register width; must match the ALU BW.
- NREG, 32, number of architectural registers; x0 is hardwired to zero.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- id_valid  input  1  id_instr holds a valid instruction this cycle.
- id_instr  input  32  instruction word.
- stall  input  1  hold the ID/EX register; the instruction is not consumed.
- flush  input  1  load a bubble into the ID/EX register.
- wb_en  input  1  register-file write enable.
- wb_rd  input  5  write address.
- wb_data  input  BW  write data (ALU res).
- ex_valid  output  1  ID/EX register holds a real instruction.
- ex_a  output  BW  ALU operand A.
- ex_b  output  BW  ALU operand B (register, sign-extended immediate, or shamt).
- ex_aluop  output  3  ALUOP, same encoding as the ALU.
- ex_rd  output  5  destination register.
- ex_we  output  1  write-back required.
- illegal  output  1  one-cycle pulse: an unsupported instruction was consumed.

Behaviour:
- All outputs are registered. Latency is 1 cycle from instruction consumption to the ex_* update.
- ALUOP encoding: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 sll, 110 srl. Code 111 is never emitted.
- Supported R-type (opcode 0110011):
  - funct3 000 with funct7 0000000 -> ADD; with funct7 0100000 -> SUB.
  - 111 AND, 110 OR, 100 XOR, 001 SLL, 101 SRL; each requires funct7 0000000.
- Supported I-type (opcode 0010011): 000 ADDI, 111 ANDI, 110 ORI, 100 XORI.
  - B = instr[31:20] sign-extended to BW.
  - 001 SLLI / 101 SRLI require instr[31:26]=000000; B = zero-extended instr[25:20].
- Operand A is always rs1 = instr[19:15]. R-type B is rs2 = instr[24:20]. ex_rd = instr[11:7].
- ex_we = 1 for every supported instruction except when rd = 0; in that case ex_we = 0 but ex_valid = 1.
- Any other encoding is illegal:
  - loads a bubble;
  - illegal = 1 for exactly one cycle (only when id_valid=1 and stall=0).
- Bubble definition: ex_valid=0, ex_we=0, ex_aluop=000, ex_a=0, ex_b=0, ex_rd=0.
- Register file:
  - NREG x BW storage, written on the clock edge when wb_en=1 and wb_rd!=0.
  - Writes to x0 are ignored; reads of x0 return 0.
  - Write-back is performed regardless of stall or flush.
- Bypass: if wb_en=1, wb_rd!=0 and wb_rd equals rs1 (or rs2) in the same cycle, the operand is wb_data, not the stale array value.
- Priority per edge, highest first:
  1. rst: bubble; illegal=0; all registers (x1..x31) cleared to 0; a wb write in that cycle is discarded.
  2. flush: bubble; illegal=0. Register write still happens.
  3. stall: ex_* hold their values; illegal=0; instruction not consumed.
  4. id_valid=0: bubble.
  5. Otherwise: decode the instruction and load ex_*.
- Reset mid-operation: the next cycle shows a bubble and an all-zero register file; no partial state survives.

Test Plan:
- Reset then ADDI x1,x0,5 (0x00500093) -> next cycle ex_valid=1, ex_a=0, ex_b=5, ex_aluop=000, ex_rd=1, ex_we=1.
- ADDI x2,x0,-1 (0xFFF00113) -> ex_b=0xFFFF_FFFF_FFFF_FFFF, ex_aluop=000.
- Bypass: wb_en=1, wb_rd=3, wb_data=0x1234 in the same cycle as SUB x4,x3,x3 (0x40318233) -> ex_a=ex_b=0x1234, ex_aluop=001. One cycle later, a read of x3 returns 0x1234 from the array.
- SLLI x5,x1,63 (0x03F09293) with x1=1 -> ex_b=63, ex_aluop=101.
- SRL x6,x1,x2 -> ex_aluop=110.
- Write to x0 with wb_data=7, then ADD x1,x0,x0 -> ex_a=0, ex_b=0.
- Stall held 3 cycles with a new instruction present -> ex_* unchanged, and the write-back lands.
- Stall and flush asserted together -> bubble.
- Illegal word 0x00000000 -> bubble plus a one-cycle illegal pulse.
- The same illegal word presented under stall -> no pulse.
- Assert rst for one cycle mid-stream -> bubble, and x1 reads 0 afterwards.
